pcap_hdr_gen: RTL and testbench
===============================

Name: pcap_hdr_gen

Overview:
- Consumes the free-running seconds/nanoseconds time base.
- Latches the time on each frame start.
- On frame end, emits a pcap per-record header (ts_sec, ts_nsec, incl_len, orig_len) as a 32-bit valid/ready word stream for the capture writer.
- After every reset, first emits the 6-word pcap global header in nanosecond-resolution format.

Parameters:
- SNAPLEN, 65535, max captured bytes; incl_len is clamped to this value; also written into the global header.
- LINKTYPE, 1, pcap network field (1 = Ethernet).
- LEN_W, 16, width of the frame length input.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- seconds  in  32  time base, whole seconds
- nanoseconds  in  32  time base, ns within the second (0..999_999_999)
- sof  in  1  single-cycle frame-start pulse
- eof  in  1  single-cycle frame-end pulse
- frame_len  in  LEN_W  frame byte count, valid with eof
- out_data  out  32  header word, little-endian host word
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the word
- out_last  out  1  marks the final word of the global header or of a record
- drop_cnt  out  16  frames dropped (saturating)
- err_cnt  out  16  eof without a matching sof (saturating)

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high. A reset mid-operation aborts any partial output and restarts with GHDR.
- Reset values: out_valid=0, out_last=0, out_data=0, drop_cnt=0, err_cnt=0, state=GHDR, word index=0, latched timestamp=0.
- Transfer rule: a word transfers only when out_valid && out_ready. While out_valid && !out_ready, out_data and out_last hold stable. out_valid never drops without a transfer.
- State GHDR:
  - out_valid asserts in the first cycle after reset deasserts.
  - Words in order: 0xA1B23C4D; 0x0004_0002 ({minor=4, major=2}); 0x0000_0000 (thiszone); 0x0000_0000 (sigfigs); SNAPLEN; LINKTYPE.
  - out_last is set on word 6. After the 6th transfer, go to WAIT_SOF.
  - sof/eof arriving in GHDR are ignored and not counted.
- State WAIT_SOF:
  - On sof: latch seconds/nanoseconds in the same cycle (a coherent pair sampled on one edge), then go to WAIT_EOF.
  - eof without sof: err_cnt+1, stay in WAIT_SOF.
  - sof and eof in the same cycle: treat as a zero-gap frame. Latch the time, take frame_len, go to EMIT.
- State WAIT_EOF:
  - On eof: orig_len = zero-extended frame_len; incl_len = min(frame_len, SNAPLEN). Go to EMIT.
  - sof without eof: drop_cnt+1 and keep the original timestamp (the earlier frame is presumed still open).
  - sof and eof in the same cycle: eof closes the current frame, sof is dropped, drop_cnt+1.
- State EMIT:
  - Latency: out_valid rises the cycle after the eof cycle.
  - Words in order: ts_sec, ts_nsec, incl_len, orig_len. out_last is set on word 4.
  - After the 4th transfer, go to WAIT_SOF. Back-to-back: a new sof can be latched in the cycle after the last transfer.
  - sof in EMIT: drop_cnt+1, no latch. eof in EMIT: err_cnt+1.
- Counters saturate at 0xFFFF.
- No arithmetic is done on the time values; they pass through verbatim.

Decomposition:
- Shared package pcap_pkg contains:
  - PCAP_MAGIC_NS = 32'hA1B23C4D
  - PCAP_VER_WORD = 32'h0004_0002
  - GHDR_WORDS = 6, REC_WORDS = 4
  - enum pcap_state_t {GHDR, WAIT_SOF, WAIT_EOF, EMIT}
  - a saturating-increment function
- No sub-module. The word mux is combinational from the word index within pcap_hdr_gen.

Test Plan:
- Reset release, out_ready=1 -> six words in consecutive cycles: A1B23C4D, 00040002, 0, 0, 0000FFFF, 00000001; out_last on the 6th only.
- Global header with out_ready toggling 1,0,0,1 -> words never skipped or duplicated; out_data stable during stalls.
- sof at seconds=5, nanoseconds=999_999_980; eof 10 cycles later with frame_len=64 -> record 5, 999999980, 64, 64; out_valid the cycle after eof.
- SNAPLEN=128, frame_len=1518 -> incl_len=128, orig_len=1518.
- Second sof in WAIT_EOF, then sof during EMIT, then a lone eof in WAIT_SOF -> drop_cnt=2, err_cnt=1; first record's timestamp unchanged.
- Reset asserted in the middle of a record (after word 2) -> out_valid=0 next cycle, counters 0; the global header re-emitted from word 1.

Source files
------------

// File: rtl/pcap_pkg.sv
// Shared constants, state type and helpers for the pcap header generator.
// Word values are host-order 32-bit words; the capture writer serialises them.
package pcap_pkg;

    localparam logic [31:0] PCAP_MAGIC_NS = 32'hA1B23C4D;
    localparam logic [31:0] PCAP_VER_WORD = 32'h0004_0002;
    localparam int          GHDR_WORDS    = 6;
    localparam int          REC_WORDS     = 4;

    typedef enum logic [1:0] {
        GHDR,
        WAIT_SOF,
        WAIT_EOF,
        EMIT
    } pcap_state_t;

    // Increment when en is set, sticking at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/pcap_hdr_gen.sv
// Emits the pcap global header after reset, then one 4-word record header per frame.
// Output handshake: a word moves only when out_valid && out_ready; while stalled the word holds.
module pcap_hdr_gen
    import pcap_pkg::*;
#(
    parameter int unsigned SNAPLEN  = 65535,
    parameter int unsigned LINKTYPE = 1,
    parameter int unsigned LEN_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      seconds,
    input  logic [31:0]      nanoseconds,
    input  logic             sof,
    input  logic             eof,
    input  logic [LEN_W-1:0] frame_len,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [15:0]      drop_cnt,
    output logic [15:0]      err_cnt,
    output pcap_state_t      dbg_state
);

    localparam logic [31:0] SNAP_W     = 32'(SNAPLEN);
    localparam logic [31:0] LINK_W     = 32'(LINKTYPE);
    localparam logic [2:0]  GHDR_LAST  = 3'(GHDR_WORDS - 1);
    localparam logic [2:0]  REC_LAST   = 3'(REC_WORDS - 1);

    pcap_state_t state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] ts_sec_q, ts_sec_d;
    logic [31:0] ts_nsec_q, ts_nsec_d;
    logic [31:0] incl_q, incl_d;
    logic [31:0] orig_q, orig_d;
    logic [15:0] drop_q, drop_d;
    logic [15:0] err_q, err_d;

    logic [31:0] len_ext;
    logic [31:0] len_clip;
    logic [31:0] word;
    logic        word_last;
    logic        emitting;
    logic        xfer;

    assign len_ext  = 32'(frame_len);
    assign len_clip = (len_ext > SNAP_W) ? SNAP_W : len_ext;

    // Word mux is driven straight from the state and word index, so it
    // cannot change during a stall because neither moves without a transfer.
    always_comb begin
        word      = 32'h0;
        word_last = 1'b0;
        case (state_q)
            GHDR: begin
                word_last = (idx_q == GHDR_LAST);
                case (idx_q)
                    3'd0:    word = PCAP_MAGIC_NS;
                    3'd1:    word = PCAP_VER_WORD;
                    3'd4:    word = SNAP_W;
                    3'd5:    word = LINK_W;
                    default: word = 32'h0;
                endcase
            end
            EMIT: begin
                word_last = (idx_q == REC_LAST);
                case (idx_q)
                    3'd0:    word = ts_sec_q;
                    3'd1:    word = ts_nsec_q;
                    3'd2:    word = incl_q;
                    default: word = orig_q;
                endcase
            end
            default: begin
                word      = 32'h0;
                word_last = 1'b0;
            end
        endcase
    end

    // Gating with reset makes the outputs idle for the whole reset pulse and
    // lets the first header word appear as soon as reset is released.
    assign emitting  = (state_q == GHDR) || (state_q == EMIT);
    assign out_valid = emitting && !reset;
    assign out_data  = out_valid ? word : 32'h0;
    assign out_last  = out_valid && word_last;
    assign xfer      = out_valid && out_ready;

    assign drop_cnt  = drop_q;
    assign err_cnt   = err_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ts_sec_d  = ts_sec_q;
        ts_nsec_d = ts_nsec_q;
        incl_d    = incl_q;
        orig_d    = orig_q;
        drop_d    = drop_q;
        err_d     = err_q;

        case (state_q)
            GHDR: begin
                if (xfer) begin
                    if (word_last) begin
                        state_d = WAIT_SOF;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            WAIT_SOF: begin
                if (sof) begin
                    ts_sec_d  = seconds;
                    ts_nsec_d = nanoseconds;
                    if (eof) begin
                        incl_d  = len_clip;
                        orig_d  = len_ext;
                        state_d = EMIT;
                    end else begin
                        state_d = WAIT_EOF;
                    end
                end else if (eof) begin
                    err_d = sat_inc16(err_q, 1'b1);
                end
            end

            WAIT_EOF: begin
                // Any sof here is a second frame start before the first closed.
                drop_d = sat_inc16(drop_q, sof);
                if (eof) begin
                    incl_d  = len_clip;
                    orig_d  = len_ext;
                    state_d = EMIT;
                end
            end

            EMIT: begin
                drop_d = sat_inc16(drop_q, sof);
                err_d  = sat_inc16(err_q, eof);
                if (xfer) begin
                    if (word_last) begin
                        state_d = WAIT_SOF;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = GHDR;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= GHDR;
            idx_q     <= 3'd0;
            ts_sec_q  <= 32'h0;
            ts_nsec_q <= 32'h0;
            incl_q    <= 32'h0;
            orig_q    <= 32'h0;
            drop_q    <= 16'h0;
            err_q     <= 16'h0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ts_sec_q  <= ts_sec_d;
            ts_nsec_q <= ts_nsec_d;
            incl_q    <= incl_d;
            orig_q    <= orig_d;
            drop_q    <= drop_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_pcap_hdr_gen.sv
// Bench for pcap_hdr_gen: two instances (default SNAPLEN and SNAPLEN=128) share all inputs;
// expected words come from a frame-level model pushed into per-instance queues.
module tb_pcap_hdr_gen;
    import pcap_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] seconds, nanoseconds;
    logic        sof, eof;
    logic [15:0] frame_len;
    logic        out_ready;

    logic [31:0] data_a, data_b;
    logic        valid_a, valid_b, last_a, last_b;
    logic [15:0] drop_a, drop_b, err_a, err_b;
    pcap_state_t st_a, st_b;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];
    int          ready_mode;
    int          rpat;
    int          exp_drop, exp_err;

    pcap_hdr_gen #(.SNAPLEN(65535), .LINKTYPE(1), .LEN_W(16)) dut_a (
        .clk(clk), .reset(reset), .seconds(seconds), .nanoseconds(nanoseconds),
        .sof(sof), .eof(eof), .frame_len(frame_len),
        .out_data(data_a), .out_valid(valid_a), .out_ready(out_ready), .out_last(last_a),
        .drop_cnt(drop_a), .err_cnt(err_a), .dbg_state(st_a)
    );

    pcap_hdr_gen #(.SNAPLEN(128), .LINKTYPE(1), .LEN_W(16)) dut_b (
        .clk(clk), .reset(reset), .seconds(seconds), .nanoseconds(nanoseconds),
        .sof(sof), .eof(eof), .frame_len(frame_len),
        .out_data(data_b), .out_valid(valid_b), .out_ready(out_ready), .out_last(last_b),
        .drop_cnt(drop_b), .err_cnt(err_b), .dbg_state(st_b)
    );

    // ---------------- check helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic fail_now(input string tag, input logic [31:0] obs);
        total++;
        bad++;
        $error("FAIL %s observed=%h expected=none", tag, obs);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        nanoseconds = nanoseconds + 32'd10;
        if (nanoseconds >= 32'd1_000_000_000) begin
            nanoseconds = nanoseconds - 32'd1_000_000_000;
            seconds     = seconds + 32'd1;
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       begin out_ready = ((rpat % 4) == 0) || ((rpat % 4) == 3); rpat++; end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic pulse(input logic s, input logic e, input logic [15:0] len);
        sof       = s;
        eof       = e;
        frame_len = len;
        tick();
        sof = 1'b0;
        eof = 1'b0;
    endtask

    task automatic push_ghdr();
        exp_a.delete();
        exp_b.delete();
        exp_a.push_back({1'b0, 32'hA1B23C4D});  exp_b.push_back({1'b0, 32'hA1B23C4D});
        exp_a.push_back({1'b0, 32'h00040002});  exp_b.push_back({1'b0, 32'h00040002});
        exp_a.push_back({1'b0, 32'h0});         exp_b.push_back({1'b0, 32'h0});
        exp_a.push_back({1'b0, 32'h0});         exp_b.push_back({1'b0, 32'h0});
        exp_a.push_back({1'b0, 32'd65535});     exp_b.push_back({1'b0, 32'd128});
        exp_a.push_back({1'b1, 32'd1});         exp_b.push_back({1'b1, 32'd1});
    endtask

    task automatic push_rec(input logic [31:0] s, input logic [31:0] ns, input int len);
        int incl_a, incl_b;
        incl_a = (len > 65535) ? 65535 : len;
        incl_b = (len > 128) ? 128 : len;
        exp_a.push_back({1'b0, s});   exp_b.push_back({1'b0, s});
        exp_a.push_back({1'b0, ns});  exp_b.push_back({1'b0, ns});
        exp_a.push_back({1'b0, 32'(incl_a)});  exp_b.push_back({1'b0, 32'(incl_b)});
        exp_a.push_back({1'b1, 32'(len)});     exp_b.push_back({1'b1, 32'(len)});
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (((exp_a.size() != 0) || (exp_b.size() != 0)) && (n < budget)) begin
            tick();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 32'(exp_a.size() + exp_b.size()), 32'h0);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_drop_a"}, 32'(drop_a), 32'(exp_drop));
        chk({tag, "_drop_b"}, 32'(drop_b), 32'(exp_drop));
        chk({tag, "_err_a"},  32'(err_a),  32'(exp_err));
        chk({tag, "_err_b"},  32'(err_b),  32'(exp_err));
    endtask

    // ---------------- scoreboard monitors ----------------
    logic        stall_a, stall_b;
    logic [32:0] prev_a, prev_b, e_a, e_b;

    always @(negedge clk) begin
        if (reset) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                chk("a_hold_valid", 32'(valid_a), 32'h1);
                chk("a_hold_word", data_a, prev_a[31:0]);
                chk("a_hold_last", 32'(last_a), 32'(prev_a[32]));
            end
            if (exp_a.size() == 0) begin
                if (valid_a !== 1'b0) fail_now("a_spurious_valid", data_a);
            end else if (valid_a && out_ready) begin
                e_a = exp_a.pop_front();
                chk("a_word", data_a, e_a[31:0]);
                chk("a_last", 32'(last_a), 32'(e_a[32]));
            end
            stall_a = valid_a && !out_ready;
            prev_a  = {last_a, data_a};
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            stall_b = 1'b0;
        end else begin
            if (stall_b) begin
                chk("b_hold_valid", 32'(valid_b), 32'h1);
                chk("b_hold_word", data_b, prev_b[31:0]);
                chk("b_hold_last", 32'(last_b), 32'(prev_b[32]));
            end
            if (exp_b.size() == 0) begin
                if (valid_b !== 1'b0) fail_now("b_spurious_valid", data_b);
            end else if (valid_b && out_ready) begin
                e_b = exp_b.pop_front();
                chk("b_word", data_b, e_b[31:0]);
                chk("b_last", 32'(last_b), 32'(e_b[32]));
            end
            stall_b = valid_b && !out_ready;
            prev_b  = {last_b, data_b};
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int          n;
        logic [31:0] s0, n0;
        int          gap, len;

        reset = 1'b1; sof = 1'b0; eof = 1'b0; frame_len = 16'h0;
        seconds = 32'h0; nanoseconds = 32'h0; out_ready = 1'b1;
        ready_mode = 0; rpat = 0; exp_drop = 0; exp_err = 0;

        // Reset state and global header at full rate.
        push_ghdr();
        tick();
        tick();
        chk("rst_valid", 32'(valid_a), 32'h0);
        chk("rst_data", data_a, 32'h0);
        chk("rst_last", 32'(last_a), 32'h0);
        chk_counters("rst");
        reset = 1'b0;
        #1;
        chk("ghdr_first_valid", 32'(valid_a), 32'h1);
        wait_idle(50, n);
        chk("ghdr_cycles", 32'(n), 32'd6);
        chk("ghdr_state", 32'(st_a), 32'(WAIT_SOF));

        // Global header under a 1,0,0,1 ready pattern; pulses here are ignored.
        reset = 1'b1;
        ready_mode = 1; rpat = 0;
        push_ghdr();
        tick();
        reset = 1'b0;
        pulse(1'b1, 1'b0, 16'd10);
        pulse(1'b0, 1'b1, 16'd10);
        wait_idle(100, n);
        chk_counters("ghdr_pulses");

        // Timestamp latch just before a second rollover, eof ten cycles later.
        ready_mode = 0;
        tick();
        seconds = 32'd5; nanoseconds = 32'd999_999_980;
        s0 = seconds; n0 = nanoseconds;
        pulse(1'b1, 1'b0, 16'd0);
        repeat (9) tick();
        chk("pre_eof_valid", 32'(valid_a), 32'h0);
        push_rec(s0, n0, 64);
        pulse(1'b0, 1'b1, 16'd64);
        chk("emit_latency_valid", 32'(valid_a), 32'h1);
        wait_idle(50, n);
        chk("rec_cycles", 32'(n), 32'd4);

        // Length above the 128-byte snap length.
        ready_mode = 2;
        s0 = seconds; n0 = nanoseconds;
        pulse(1'b1, 1'b0, 16'd0);
        tick();
        push_rec(s0, n0, 1518);
        pulse(1'b0, 1'b1, 16'd1518);
        wait_idle(100, n);

        // Drops and errors: second sof, sof+eof in WAIT_EOF, sof/eof in EMIT, lone eof.
        ready_mode = 1; rpat = 0;
        s0 = seconds; n0 = nanoseconds;
        pulse(1'b1, 1'b0, 16'd0);
        repeat (3) tick();
        pulse(1'b1, 1'b0, 16'd0);
        exp_drop++;
        repeat (2) tick();
        push_rec(s0, n0, 100);
        pulse(1'b1, 1'b1, 16'd100);
        exp_drop++;
        pulse(1'b1, 1'b0, 16'd0);
        exp_drop++;
        pulse(1'b0, 1'b1, 16'd7);
        exp_err++;
        wait_idle(100, n);
        pulse(1'b0, 1'b1, 16'd9);
        exp_err++;
        chk_counters("drop_err");
        chk("drop_err_state", 32'(st_b), 32'(WAIT_SOF));

        // Random frames, back-to-back after each drain, random ready.
        ready_mode = 2;
        for (int i = 0; i < 24; i++) begin
            seconds     = $urandom;
            nanoseconds = $urandom_range(0, 999_999_999);
            gap         = $urandom_range(0, 5);
            len         = (i % 3 == 0) ? $urandom_range(0, 200) : $urandom_range(0, 65535);
            s0 = seconds; n0 = nanoseconds;
            if (gap == 0) begin
                push_rec(s0, n0, len);
                pulse(1'b1, 1'b1, 16'(len));
            end else begin
                pulse(1'b1, 1'b0, 16'd0);
                repeat (gap - 1) tick();
                push_rec(s0, n0, len);
                pulse(1'b0, 1'b1, 16'(len));
            end
            wait_idle(200, n);
        end
        chk_counters("random");

        // Reset in the middle of a record after two words.
        ready_mode = 0;
        tick();
        s0 = seconds; n0 = nanoseconds;
        pulse(1'b1, 1'b0, 16'd0);
        push_rec(s0, n0, 200);
        pulse(1'b0, 1'b1, 16'd200);
        tick();
        tick();
        reset = 1'b1;
        push_ghdr();
        exp_drop = 0; exp_err = 0;
        tick();
        chk("midrst_valid", 32'(valid_a), 32'h0);
        chk("midrst_data", data_b, 32'h0);
        chk_counters("midrst");
        reset = 1'b0;
        #1;
        chk("midrst_ghdr_valid", 32'(valid_a), 32'h1);
        chk("midrst_ghdr_word1", data_a, 32'hA1B23C4D);
        wait_idle(50, n);
        chk("midrst_ghdr_cycles", 32'(n), 32'd6);

        tick();
        chk("end_queue_a", 32'(exp_a.size()), 32'h0);
        chk("end_queue_b", 32'(exp_b.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
